// File: rtl/key_message_bank.sv
// Editable key/message tables for the DES datapath: nibble-wise staging, commit into
// a selected entry, and a registered valid/ready offer of the selected pair.
module key_message_bank #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEL_W-1:0]  key_sel,
  input  logic [SEL_W-1:0]  msg_sel,
  input  logic [3:0]        wr_nibble,
  input  logic              wr_push,
  input  logic              wr_clear,
  input  logic              wr_chan,
  input  logic              wr_commit,
  input  logic              load_req,
  output logic [DATA_W-1:0] out_key,
  output logic [DATA_W-1:0] out_msg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              stage_full,
  output logic              wr_err
);

  localparam int NIB   = DATA_W / 4;
  localparam int CNT_W = $clog2(NIB + 1);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   key_q [DEPTH];
  logic [DATA_W-1:0]   msg_q [DEPTH];
  logic [DATA_W-1:0]   stage_q, stage_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   out_key_q, out_msg_q;
  logic                full_q, full_d;
  logic                err_q, err_d;
  logic                wr_key_en, wr_msg_en, capture;

  function automatic logic [DATA_W-1:0] rep_nib(input logic [3:0] n);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < NIB; k++) r[k*4 +: 4] = n;
    return r;
  endfunction

  // Staging/commit: a commit overrides a simultaneous push; clear still applies after it.
  always_comb begin
    stage_d   = stage_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    wr_key_en = 1'b0;
    wr_msg_en = 1'b0;
    if (wr_commit) begin
      if (cnt_q == CNT_W'(NIB)) begin
        wr_key_en = ~wr_chan;
        wr_msg_en = wr_chan;
        stage_d   = '0;
        cnt_d     = '0;
      end else begin
        err_d = 1'b1;
      end
      if (wr_clear) begin
        stage_d = '0;
        cnt_d   = '0;
      end
    end else if (wr_clear) begin
      stage_d = '0;
      cnt_d   = '0;
    end else if (wr_push) begin
      stage_d = {stage_q[DATA_W-5:0], wr_nibble};
      if (cnt_q != CNT_W'(NIB)) cnt_d = cnt_q + CNT_W'(1);
    end
    full_d = (cnt_d == CNT_W'(NIB));
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_req) begin
          state_d = OFFER;
          capture = 1'b1;
        end
      end
      OFFER: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  // Capture reads the table registers, so a same-cycle commit is not yet visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_key_q <= '0;
      out_msg_q <= '0;
    end else if (capture) begin
      out_key_q <= key_q[key_sel];
      out_msg_q <= msg_q[msg_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i] <= rep_nib(4'(i));
        msg_q[i] <= rep_nib(~4'(i));
      end
    end else begin
      if (wr_key_en) key_q[key_sel] <= stage_q;
      if (wr_msg_en) msg_q[msg_sel] <= stage_q;
    end
  end

  assign out_key    = out_key_q;
  assign out_msg    = out_msg_q;
  assign out_valid  = (state_q == OFFER);
  assign stage_full = full_q;
  assign wr_err     = err_q;

endmodule

// File: tb/tb_key_message_bank.sv
// Randomized and directed bench for key_message_bank, checked every cycle against a
// queue/array model of the tables, staging and offer handshake.
module tb_key_message_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  key_sel = '0, msg_sel = '0, wr_nibble = '0;
  logic        wr_push = 1'b0, wr_clear = 1'b0, wr_chan = 1'b0, wr_commit = 1'b0;
  logic        load_req = 1'b0, out_ready = 1'b0;
  logic [63:0] out_key, out_msg;
  logic        out_valid, stage_full, wr_err;

  int checks = 0;
  int errors = 0;

  key_message_bank #(.DATA_W(64), .DEPTH(16), .SEL_W(4)) dut (
    .clk(clk), .rst(rst), .key_sel(key_sel), .msg_sel(msg_sel),
    .wr_nibble(wr_nibble), .wr_push(wr_push), .wr_clear(wr_clear),
    .wr_chan(wr_chan), .wr_commit(wr_commit), .load_req(load_req),
    .out_key(out_key), .out_msg(out_msg), .out_valid(out_valid),
    .out_ready(out_ready), .stage_full(stage_full), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [63:0] ktab [16];
  logic [63:0] mtab [16];
  logic [3:0]  sq [$];
  logic [63:0] m_key, m_msg;
  bit          m_valid, m_full, m_err;

  function automatic logic [63:0] pattern(input logic [3:0] n);
    logic [63:0] r = '0;
    for (int k = 0; k < 16; k++) r = {r[59:0], n};
    return r;
  endfunction

  function automatic logic [63:0] stage_val();
    logic [63:0] r = '0;
    foreach (sq[i]) r = {r[59:0], sq[i]};
    return r;
  endfunction

  task automatic model_step();
    logic [63:0] sv;
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        ktab[i] = pattern(4'(i));
        mtab[i] = pattern(~4'(i));
      end
      sq.delete();
      m_key = '0; m_msg = '0; m_valid = 0; m_full = 0; m_err = 0;
      return;
    end
    if (!m_valid && load_req) begin
      m_key = ktab[key_sel];
      m_msg = mtab[msg_sel];
      m_valid = 1;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    m_err = 0;
    sv = stage_val();
    if (wr_commit) begin
      if (sq.size() == 16) begin
        if (wr_chan) mtab[msg_sel] = sv; else ktab[key_sel] = sv;
        sq.delete();
      end else begin
        m_err = 1;
      end
      if (wr_clear) sq.delete();
    end else if (wr_clear) begin
      sq.delete();
    end else if (wr_push) begin
      sq.push_back(wr_nibble);
      if (sq.size() > 16) void'(sq.pop_front());
    end
    m_full = (sq.size() == 16);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_key", out_key, m_key);
    chk("out_msg", out_msg, m_msg);
    chk("stage_full", 64'(stage_full), 64'(m_full));
    chk("wr_err", 64'(wr_err), 64'(m_err));
    wr_push = 0; wr_clear = 0; wr_commit = 0; load_req = 0;
  endtask

  initial begin
    // Reset and first load
    rst = 1; tick(); rst = 0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_key", out_key, 64'd0);
    key_sel = 3; msg_sel = 3; load_req = 1; tick();
    chk("lit_valid3", 64'(out_valid), 64'd1);
    chk("lit_key3", out_key, 64'h3333333333333333);
    chk("lit_msg3", out_msg, 64'hCCCCCCCCCCCCCCCC);
    out_ready = 1; tick(); out_ready = 0;
    chk("lit_accept", 64'(out_valid), 64'd0);

    // Full commit into key 5
    wr_chan = 0; key_sel = 5;
    for (int n = 0; n < 16; n++) begin wr_nibble = 4'(n); wr_push = 1; tick(); end
    chk("lit_full", 64'(stage_full), 64'd1);
    wr_commit = 1; tick();
    chk("lit_full_clr", 64'(stage_full), 64'd0);
    load_req = 1; tick();
    chk("lit_key5", out_key, 64'h0123456789ABCDEF);
    out_ready = 1; tick(); out_ready = 0;

    // Short commit rejected
    key_sel = 6;
    for (int n = 0; n < 15; n++) begin wr_nibble = 4'hA; wr_push = 1; tick(); end
    wr_commit = 1; tick();
    chk("lit_err_on", 64'(wr_err), 64'd1);
    tick();
    chk("lit_err_off", 64'(wr_err), 64'd0);
    wr_clear = 1; tick();
    load_req = 1; tick();
    chk("lit_key6", out_key, 64'h6666666666666666);
    out_ready = 1; tick(); out_ready = 0;

    // 18 pushes, oldest two drop; commit to message 0
    wr_chan = 1; msg_sel = 0;
    wr_nibble = 4'h1; wr_push = 1; tick();
    wr_nibble = 4'h2; wr_push = 1; tick();
    for (int n = 0; n < 16; n++) begin wr_nibble = 4'(n); wr_push = 1; tick(); end
    wr_commit = 1; tick();
    load_req = 1; tick();
    chk("lit_msg0", out_msg, 64'h0123456789ABCDEF);
    out_ready = 1; tick(); out_ready = 0;

    // Stall in OFFER
    key_sel = 5; load_req = 1; tick();
    for (int n = 0; n < 10; n++) begin
      key_sel = 4'($urandom); load_req = 1; tick();
      chk("lit_hold_key", out_key, 64'h0123456789ABCDEF);
      chk("lit_hold_vld", 64'(out_valid), 64'd1);
    end
    out_ready = 1; tick(); out_ready = 0;
    chk("lit_release", 64'(out_valid), 64'd0);

    // Reset during OFFER restores modified entry
    key_sel = 5; load_req = 1; tick();
    rst = 1; tick(); rst = 0;
    chk("lit_rst_vld", 64'(out_valid), 64'd0);
    load_req = 1; tick();
    chk("lit_key5_rst", out_key, 64'h5555555555555555);
    out_ready = 1; tick(); out_ready = 0;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      key_sel   = 4'($urandom);
      msg_sel   = 4'($urandom);
      wr_nibble = 4'($urandom);
      wr_chan   = 1'($urandom);
      wr_push   = ($urandom_range(0, 99) < 60);
      wr_clear  = ($urandom_range(0, 99) < 3);
      wr_commit = ($urandom_range(0, 99) < 8);
      load_req  = ($urandom_range(0, 99) < 20);
      out_ready = ($urandom_range(0, 99) < 40);
      tick();
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
